// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared constants, state enum and character lookup for morse_tx
package morse_pkg;

    localparam int NUM_CODES = 36;
    localparam int MAX_SYMS  = 5;

    typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} morse_state_t;

    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pat;
    } morse_entry_t;

    // Patterns are left-aligned: the first symbol sits in pat[4], 1 = dash.
    function automatic morse_entry_t morse_lookup(input int code);
        morse_entry_t e;
        e = '0;
        if (code >= 0 && code < NUM_CODES) begin
            case (code)
                0:  e = {3'd2, 5'b01000};
                1:  e = {3'd4, 5'b10000};
                2:  e = {3'd4, 5'b10100};
                3:  e = {3'd3, 5'b10000};
                4:  e = {3'd1, 5'b00000};
                5:  e = {3'd4, 5'b00100};
                6:  e = {3'd3, 5'b11000};
                7:  e = {3'd4, 5'b00000};
                8:  e = {3'd2, 5'b00000};
                9:  e = {3'd4, 5'b01110};
                10: e = {3'd3, 5'b10100};
                11: e = {3'd4, 5'b01000};
                12: e = {3'd2, 5'b11000};
                13: e = {3'd2, 5'b10000};
                14: e = {3'd3, 5'b11100};
                15: e = {3'd4, 5'b01100};
                16: e = {3'd4, 5'b11010};
                17: e = {3'd3, 5'b01000};
                18: e = {3'd3, 5'b00000};
                19: e = {3'd1, 5'b10000};
                20: e = {3'd3, 5'b00100};
                21: e = {3'd4, 5'b00010};
                22: e = {3'd3, 5'b01100};
                23: e = {3'd4, 5'b10010};
                24: e = {3'd4, 5'b10110};
                25: e = {3'd4, 5'b11000};
                26: e = {3'd5, 5'b11111};
                27: e = {3'd5, 5'b01111};
                28: e = {3'd5, 5'b00111};
                29: e = {3'd5, 5'b00011};
                30: e = {3'd5, 5'b00001};
                31: e = {3'd5, 5'b00000};
                32: e = {3'd5, 5'b10000};
                33: e = {3'd5, 5'b11000};
                34: e = {3'd5, 5'b11100};
                35: e = {3'd5, 5'b11110};
                default: e = '0;
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/morse_tx_if.sv
// rtl/morse_tx_if.sv - request/status bundle between key logic and morse_tx
interface morse_tx_if #(parameter int CODE_W = 6) ();
    logic              start;
    logic [CODE_W-1:0] char_code;
    logic              busy;
    logic              done;
    logic              err;

    modport master (output start, char_code, input busy, done, err);
    modport slave  (input start, char_code, output busy, done, err);
endinterface

// File: rtl/morse_tx_unit_tick.sv
// rtl/morse_tx_unit_tick.sv - unit prescaler, one tick every TICKS cycles
module unit_tick #(
    parameter int TICKS = 25000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);
    localparam int CW = $clog2(TICKS);

    logic [CW-1:0] count;

    assign tick = (count == CW'(TICKS - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clear || tick)
            count <= '0;
        else
            count <= count + CW'(1);
    end
endmodule

// File: rtl/morse_tx.sv
// rtl/morse_tx.sv - Morse code transmitter driving a single LED
module morse_tx
    import morse_pkg::*;
#(
    parameter int UNIT_TICKS = 25000000,
    parameter int GAP_UNITS  = 3,
    parameter int CODE_W     = 6
) (
    input  logic       clock,
    input  logic       reset_n,
    morse_tx_if.slave  bus,
    output logic       led
);
    localparam int UNIT_MAX = (GAP_UNITS > 3) ? GAP_UNITS : 3;
    localparam int UW       = $clog2(UNIT_MAX);
    localparam int SW       = $clog2(MAX_SYMS);

    morse_state_t      state;
    logic [4:0]        pat;
    logic [SW-1:0]     syms_left;
    logic [UW-1:0]     unit_cnt;
    logic [CODE_W-1:0] code;
    morse_entry_t      entry;
    logic              tick;
    logic              tick_clear;

    assign code       = bus.char_code;
    assign entry      = morse_lookup(int'(code));
    assign tick_clear = (state == IDLE);

    unit_tick #(.TICKS(UNIT_TICKS)) u_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (tick_clear),
        .tick    (tick)
    );

    // unit_cnt holds the units still to run in the current state, minus one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pat       <= '0;
            syms_left <= '0;
            unit_cnt  <= '0;
            led       <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.err   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (entry.len != 3'd0) begin
                            pat       <= entry.pat;
                            syms_left <= SW'(entry.len - 3'd1);
                            unit_cnt  <= entry.pat[4] ? UW'(2) : '0;
                            led       <= 1'b1;
                            bus.busy  <= 1'b1;
                            state     <= MARK;
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (tick) begin
                        if (unit_cnt != '0) begin
                            unit_cnt <= unit_cnt - UW'(1);
                        end else if (syms_left != '0) begin
                            led      <= 1'b0;
                            state    <= SPACE;
                        end else begin
                            led      <= 1'b0;
                            unit_cnt <= UW'(GAP_UNITS - 1);
                            state    <= GAP;
                        end
                    end
                end
                SPACE: begin
                    if (tick) begin
                        pat       <= {pat[3:0], 1'b0};
                        syms_left <= syms_left - SW'(1);
                        unit_cnt  <= pat[3] ? UW'(2) : '0;
                        led       <= 1'b1;
                        state     <= MARK;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (unit_cnt != '0) begin
                            unit_cnt <= unit_cnt - UW'(1);
                        end else begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_tx.sv
// tb/tb_morse_tx.sv - self-checking bench for morse_tx
module tb_morse_tx;
    localparam int UT    = 4;
    localparam int GAP_U = 3;

    logic clock = 1'b0;
    logic reset_n;
    logic led;

    morse_tx_if #(.CODE_W(6)) bus ();

    morse_tx #(.UNIT_TICKS(UT), .GAP_UNITS(GAP_U), .CODE_W(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .led     (led)
    );

    always #5 clock = ~clock;

    typedef struct {
        int code;
        int exp_n;
        int disturb_at;
        int disturb_code;
    } vec_t;

    string morse_str [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-",
        "...-", ".--", "-..-", "-.--", "--..", "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----."};

    int checks = 0;
    int errors = 0;
    bit exp_led [$];
    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference waveform for one character, one entry per cycle after acceptance.
    function automatic void build_wave(input int code);
        string s;
        s = morse_str[code];
        exp_led.delete();
        for (int i = 0; i < s.len(); i++) begin
            int m;
            m = (s[i] == 8'h2d) ? 3 : 1;
            repeat (m * UT) exp_led.push_back(1'b1);
            if (i != s.len() - 1) repeat (UT) exp_led.push_back(1'b0);
        end
        repeat (GAP_U * UT) exp_led.push_back(1'b0);
    endfunction

    task automatic run_char(input int code, input int exp_n, input int disturb_at,
                            input int disturb_code, input int next_code, input bit prestarted);
        int n;
        build_wave(code);
        n = (exp_n > 0) ? exp_n : exp_led.size();
        if (!prestarted) begin
            @(negedge clock);
            bus.start = 1'b1;
            bus.char_code = 6'(code);
        end
        @(posedge clock);
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clock);
            check($sformatf("led c%0d k%0d", code, k), led,
                  (k <= exp_led.size()) ? int'(exp_led[k-1]) : 0);
            check($sformatf("busy c%0d k%0d", code, k), bus.busy, (k <= n) ? 1 : 0);
            check($sformatf("done c%0d k%0d", code, k), bus.done, (k == n + 1) ? 1 : 0);
            check($sformatf("err c%0d k%0d", code, k), bus.err, 0);
            bus.start = 1'b0;
            if (k == disturb_at) begin
                bus.start = 1'b1;
                bus.char_code = 6'(disturb_code);
            end
            if (k == n + 1 && next_code >= 0) begin
                bus.start = 1'b1;
                bus.char_code = 6'(next_code);
            end
        end
    endtask

    task automatic run_invalid(input int code);
        @(negedge clock);
        bus.start = 1'b1;
        bus.char_code = 6'(code);
        @(negedge clock);
        bus.start = 1'b0;
        check($sformatf("err pulse c%0d", code), bus.err, 1);
        check($sformatf("err busy c%0d", code), bus.busy, 0);
        check($sformatf("err led c%0d", code), led, 0);
        @(negedge clock);
        check($sformatf("err clear c%0d", code), bus.err, 0);
        check($sformatf("err idle busy c%0d", code), bus.busy, 0);
    endtask

    initial begin
        vecs[0] = '{4, 16, 0, 0};
        vecs[1] = '{0, 32, 0, 0};
        vecs[2] = '{26, 88, 0, 0};
        vecs[3] = '{4, 16, 6, 1};
        vecs[4] = '{40, 0, 0, 0};
        vecs[5] = '{19, 24, 0, 0};
        vecs[6] = '{31, 48, 10, 63};
        vecs[7] = '{35, 80, 0, 0};
        vecs[8] = '{36, 0, 0, 0};

        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.char_code = '0;
        repeat (3) @(negedge clock);
        check("reset led", led, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset err", bus.err, 0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].exp_n == 0)
                run_invalid(vecs[i].code);
            else
                run_char(vecs[i].code, vecs[i].exp_n, vecs[i].disturb_at,
                         vecs[i].disturb_code, -1, 1'b0);
        end

        // Back-to-back: second start held during the done cycle.
        run_char(4, 16, 0, 0, 4, 1'b0);
        run_char(4, 16, 0, 0, -1, 1'b1);

        // Asynchronous abort in the middle of the A dash.
        @(negedge clock);
        bus.start = 1'b1;
        bus.char_code = 6'd0;
        @(posedge clock);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            bus.start = 1'b0;
        end
        check("abort pre led", led, 1);
        reset_n = 1'b0;
        #1;
        check("abort led", led, 0);
        check("abort busy", bus.busy, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            check("abort no done", bus.done, 0);
            check("abort idle busy", bus.busy, 0);
        end
        run_char(4, 16, 0, 0, -1, 1'b0);

        for (int r = 0; r < 24; r++) begin
            int code;
            code = int'($urandom_range(0, 40));
            if (code > 35) begin
                run_invalid(code);
            end else begin
                int d;
                build_wave(code);
                d = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, exp_led.size())) : 0;
                run_char(code, 0, d, int'($urandom_range(0, 63)), -1, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/morse_tx.md
Name: morse_tx

Overview:
- Parametrised Morse code transmitter driving a single LED output.
- Covers the full A–Z and 0–9 set, with standard Morse timing: dot = 1 unit, dash = 3 units, intra-character space = 1 unit, inter-character gap = GAP_UNITS.
- Runs in a single clock domain with a tick-enable prescaler; no derived clocks.
- Sits between the switch/key input logic and the LEDR output on the board top level.

Parameters:
- UNIT_TICKS, 25000000, clock cycles per Morse unit (0.5 s at 50 MHz); minimum 2.
- GAP_UNITS, 3, units of LED-off appended after the last symbol of a character; minimum 1.
- CODE_W, 6, width of char_code.

Ports:
- clock      input   1       system clock, rising edge
- reset_n    input   1       asynchronous, active-low reset
- start      input   1       request to send char_code; level-sampled, one cycle suffices
- char_code  input   CODE_W  0–25 = A–Z, 26–35 = digits 0–9; values above 35 are invalid
- busy       output  1       transmission in progress
- done       output  1       one-cycle pulse when the character, including its gap, completes
- err        output  1       one-cycle pulse when start is presented with an invalid code
- led        output  1       Morse output, 1 = on

Behaviour:
- Reset (asynchronous): led=0, busy=0, done=0, err=0; state IDLE; prescaler and unit counters cleared.
- States: IDLE, MARK, SPACE, GAP.
- Acceptance:
  - start=1 while in IDLE with char_code ≤ 35 is accepted at that edge.
  - char_code is latched only at acceptance. Latched values: length len (1–5) and pattern pat[4:0], MSB-first, 1 = dash.
  - Prescaler is cleared at acceptance.
  - Next cycle: state=MARK, led=1, busy=1.
- Invalid code: start=1 in IDLE with char_code > 35 gives err=1 for the next cycle only. No other change; busy stays 0.
- Start while busy: ignored; no err.
- Tick: the prescaler counts 0..UNIT_TICKS-1 and pulses tick on the terminal count, then wraps to 0. Each unit is therefore exactly UNIT_TICKS cycles.
- MARK:
  - Duration is 1 unit for a dot, 3 units for a dash; led=1.
  - On the final tick: go to SPACE if symbols remain, else go to GAP.
- SPACE: 1 unit, led=0; then MARK for the next symbol.
- GAP: GAP_UNITS units, led=0. On the final tick: state=IDLE, busy=0 and done=1 in the same cycle.
- Back-to-back: the done cycle is IDLE, so a start presented in that cycle is accepted. led then rises on the following cycle.
- Timing rule: busy duration in cycles is UNIT_TICKS × (sum of mark units + (len−1) + GAP_UNITS).
- Reset mid-operation: immediate abort. led=0, busy=0, and no done pulse.
- Outputs are registered; there is no combinational path from start to led.

Decomposition:
- Package morse_pkg holds:
  - constants NUM_CODES=36 and MAX_SYMS=5;
  - function morse_lookup(code) returning {len[2:0], pat[4:0]} for codes 0–35, with len=0 for invalid codes;
  - the state enum {IDLE, MARK, SPACE, GAP}.
- Sub-module unit_tick (params TICKS; ports clock, reset_n, clear, tick): the prescaler, also reusable by other timed display blocks.
- The FSM, symbol index and unit counter stay in morse_tx.

Test Plan:
All scenarios run with UNIT_TICKS=4, GAP_UNITS=3; start is accepted at edge 0.
- E (code 4) → led=1 in cycles 1–4 and 0 in cycles 5–16; busy=1 in 1–16; done=1 at cycle 17 only.
- A (code 0) → led high 1–4, low 5–8, high 9–20, low 21–32; done at 33; err never asserted.
- Digit 0 (code 26), five dashes → five 12-cycle led pulses separated by 4-cycle lows; done at cycle 1+60+16+12=89.
- Second start (code 1) issued at cycle 6 during E → ignored, timing identical to the E case. Code 40 in IDLE → err=1 for one cycle, busy=0, led=0.
- reset_n pulled low at cycle 10 during the A dash → led=0 and busy=0 asynchronously; no done. After release, start with code 4 behaves as the E case.
- Back-to-back: E, then start with code 4 held at the done cycle (17) → accepted; led rises at cycle 18; second done at cycle 34.
